led_blink_scheduler: RTL and testbench
======================================

// Module: led_blink_scheduler
// PURPOSE
//   Round-robin scheduler that shares the board LED bank among N_REQ requesters.
//   Each granted requester gets BLINKS on/off cycles of its own LED pattern,
//   timed from CLOCK_50 by an internal tick divider, then the LEDs move to the next requester.
//   Sits between status sources (FSMs, error flags) and the physical LED pins.
// PARAMETERS
//   CLK_HZ   50000000  input clock frequency in Hz
//   TICK_HZ  2         phase-change rate in Hz; DIV = CLK_HZ/TICK_HZ clocks per phase, DIV >= 2
//   N_REQ    4         number of requesters, >= 2
//   LED_W    2         LED bank width
//   BLINKS   4         on+off cycles per grant, >= 1
// PORTS
//   CLOCK_50  in   1            system clock, all logic on rising edge
//   RESET     in   1            synchronous, active-high reset
//   REQ       in   N_REQ        level request per requester
//   PATTERN   in   N_REQ*LED_W  on-phase pattern; requester i uses [i*LED_W +: LED_W]
//   GNT       out  N_REQ        one-hot grant, registered
//   DONE      out  N_REQ        1-cycle pulse on the granted bit when its grant completes normally
//   BUSY      out  1            high in ON/OFF
//   LED       out  LED_W        LED drive, registered
// BEHAVIOUR
//   - Reset values: GNT=0, DONE=0, BUSY=0, LED=0, state=IDLE, tick_cnt=0, phase_cnt=0, last=N_REQ-1.
//     With last=N_REQ-1, requester 0 has top priority after reset.
//   - Tick divider: tick_cnt counts 0..DIV-1 and wraps. tick=1 when tick_cnt==DIV-1.
//     tick_cnt is cleared on every grant, so each phase is exactly DIV clocks.
//   - IDLE: LED=0.
//     If |REQ, the next edge grants the first set REQ bit scanning last+1, last+2, ... modulo N_REQ.
//     On that edge: GNT one-hot, last=index, pattern latched, phase_cnt=0, state=ON.
//     LED shows the pattern on the same edge GNT rises (latency 1 clock from REQ).
//   - ON: LED=latched pattern. On tick -> OFF.
//   - OFF: LED=0. On tick:
//     * phase_cnt==BLINKS-1: DONE[idx]=1 for 1 cycle, GNT=0, LED=0, state=IDLE.
//     * otherwise: phase_cnt++ and state=ON.
//   - Grant length is exactly 2*BLINKS*DIV clocks. There is at least one IDLE cycle between grants.
//   - PATTERN changes during a grant are ignored, because the pattern is latched at grant time.
//   - REQ[idx] deasserted in ON/OFF: abort on the next edge.
//     Abort sets GNT=0, LED=0 and state=IDLE; no DONE pulse. last still advances to idx.
//   - REQ[idx] deasserting on the same edge as final-OFF tick: normal completion wins and DONE pulses.
//   - REQ from non-granted requesters is ignored until IDLE. No pre-emption.
//   - RESET mid-grant: all outputs return to reset values on that edge. No DONE pulse.
//   - Widths: tick_cnt is $clog2(DIV) bits; phase_cnt is max(1,$clog2(BLINKS)) bits; no overflow is reachable.
// CONFIGURATION
//   LED_COMPLEMENT_EN defined: OFF phase drives LED = ~latched pattern (complementary pair blink).
//     IDLE still drives LED=0.
//   LED_COMPLEMENT_EN undefined: OFF phase drives LED=0.
// STRUCTURE
//   - Package led_sched_pkg: state encoding ST_IDLE/ST_ON/ST_OFF (2-bit) and a clog2 helper function.
//   - Sub-module tick_divider #(DIV): ports CLOCK_50, RESET, clr, tick.
//     Instantiated once; clr is asserted on grant.
//   - The round-robin pick is a combinational function inside the top module.
// TESTING (bench params: CLK_HZ=20, TICK_HZ=2 -> DIV=10, N_REQ=4, LED_W=2, BLINKS=2)
//   1. RESET, then REQ=4'b0001, PATTERN[1:0]=2'b01 ->
//      GNT=0001 one clock later; LED=01 for 10 clocks, then 00 for 10, then 01 for 10, then 00 for 10.
//      DONE[0] pulses at clock 40 after grant; grant length is 40 clocks.
//   2. REQ=4'b1111 held -> grant order 0,1,2,3,0.
//      Each grant lasts 40 clocks, separated by exactly 1 IDLE cycle.
//   3. Grant to 2 active; drop REQ[2] at clock 15 of the grant ->
//      next edge GNT=0, LED=0, no DONE; a pending REQ[3] is granted 1 clock later.
//   4. RESET asserted at clock 25 of a grant -> next edge GNT=0, LED=0, BUSY=0, no DONE.
//      After release with REQ=1111, requester 0 is granted first.
//   5. Change PATTERN[1:0] 01->10 mid-grant -> LED keeps showing 01 for the rest of the grant.
//   6. Build with LED_COMPLEMENT_EN, PATTERN=01 -> ON phase LED=01, OFF phase LED=10, IDLE LED=00.

Source files
------------

// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and helpers for the LED blink scheduler
// Purpose: scheduler state encoding and a constant-evaluable clog2 helper.
// Ports: none (package).
package led_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  // Smallest r with 2**r >= value; usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_divider.sv
// rtl/led_blink_scheduler_tick_divider.sv - free-running phase tick divider
// Purpose: counts 0..DIV-1 and wraps; tick is high on the last count.
// Ports:
//   CLOCK_50 in  system clock
//   RESET    in  synchronous active-high reset
//   clr      in  restart the count at 0 on the next edge (asserted on grant)
//   tick     out high while the count is DIV-1
module tick_divider
  import led_sched_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - round-robin LED bank sharing among requesters
// Purpose: grants the LED bank to one requester at a time for BLINKS on/off
//   cycles of its latched pattern, each phase DIV = CLK_HZ/TICK_HZ clocks.
// Build option: LED_COMPLEMENT_EN drives ~pattern during OFF instead of 0.
// Ports:
//   CLOCK_50 in  system clock
//   RESET    in  synchronous active-high reset
//   REQ      in  [N_REQ]       level request per requester
//   PATTERN  in  [N_REQ*LED_W] on-phase pattern, requester i at [i*LED_W +: LED_W]
//   GNT      out [N_REQ]       one-hot registered grant
//   DONE     out [N_REQ]       one-cycle pulse when a grant completes normally
//   BUSY     out               high in ON/OFF
//   LED      out [LED_W]       registered LED drive
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 2,
  parameter int N_REQ   = 4,
  parameter int LED_W   = 2,
  parameter int BLINKS  = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  input  logic [N_REQ-1:0]       REQ,
  input  logic [N_REQ*LED_W-1:0] PATTERN,
  output logic [N_REQ-1:0]       GNT,
  output logic [N_REQ-1:0]       DONE,
  output logic                   BUSY,
  output logic [LED_W-1:0]       LED
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int IW  = clog2(N_REQ);
  localparam int PW  = (clog2(BLINKS) < 1) ? 1 : clog2(BLINKS);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [LED_W-1:0] pat_q, pat_d;
  logic [IW-1:0]    last_q, last_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             tick;
  logic             clr;
  logic [IW:0]      pick;

  // Returns {found, index}: first set request scanning last+1, last+2, ...
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [IW-1:0]    last);
    logic          found;
    logic [IW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = int'(last) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    return {found, idx};
  endfunction

  tick_divider #(.DIV(DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .clr      (clr),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    pat_d   = pat_q;
    last_d  = last_q;
    phase_d = phase_q;
    clr     = 1'b0;
    pick    = rr_pick(REQ, last_q);

    case (state_q)
      ST_IDLE: begin
        if (pick[IW]) begin
          state_d             = ST_ON;
          gnt_d               = '0;
          gnt_d[pick[IW-1:0]] = 1'b1;
          last_d              = pick[IW-1:0];
          pat_d               = PATTERN[pick[IW-1:0]*LED_W +: LED_W];
          phase_d             = '0;
          clr                 = 1'b1;
        end
      end
      ST_ON: begin
        if (!REQ[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (tick) begin
          state_d = ST_OFF;
        end
      end
      ST_OFF: begin
        // Final tick is checked before the abort so completion wins a tie.
        if (tick && (phase_q == PW'(BLINKS - 1))) begin
          state_d = ST_IDLE;
          done_d  = gnt_q;
          gnt_d   = '0;
        end else if (!REQ[last_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (tick) begin
          state_d = ST_ON;
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    // LED follows the next state so it changes on the same edge as GNT.
    case (state_d)
      ST_ON:   led_d = pat_d;
`ifdef LED_COMPLEMENT_EN
      ST_OFF:  led_d = ~pat_d;
`else
      ST_OFF:  led_d = '0;
`endif
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      led_q   <= '0;
      pat_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      led_q   <= led_d;
      pat_q   <= pat_d;
      last_q  <= last_d;
      phase_q <= phase_d;
    end
  end

  assign GNT  = gnt_q;
  assign DONE = done_q;
  assign LED  = led_q;
  assign BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb/tb_led_blink_scheduler.sv - directed self-checking bench for led_blink_scheduler
module tb_led_blink_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] pattern;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;
  logic [1:0] led;

  int n_cmp;
  int n_err;

  led_blink_scheduler #(
    .CLK_HZ (20),
    .TICK_HZ(2),
    .N_REQ  (4),
    .LED_W  (2),
    .BLINKS (2)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .REQ     (req),
    .PATTERN (pattern),
    .GNT     (gnt),
    .DONE    (done),
    .BUSY    (busy),
    .LED     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] off_of(input logic [1:0] p);
`ifdef LED_COMPLEMENT_EN
    return ~p;
`else
    return 2'b00 & p;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b0000;
    pattern = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gnt, done, busy, led} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_outputs gnt=%b done=%b busy=%b led=%b want all 0", gnt, done, busy, led);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0 || busy !== 1'b0 || led !== 2'b00) begin
      n_err++;
      $display("FAIL idle_no_req gnt=%b busy=%b led=%b want 0", gnt, busy, led);
    end
  endtask

  task automatic test_single_grant();
    logic [1:0] exp_led;
    do_reset();
    pattern = 8'b00_00_00_01;
    req = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      exp_led = (((c / 10) % 2) == 0) ? 2'b01 : off_of(2'b01);
      n_cmp++;
      if (led !== exp_led) begin
        n_err++;
        $display("FAIL single_led c=%0d got %b want %b", c, led, exp_led);
      end
      n_cmp++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || done !== 4'b0000) begin
        n_err++;
        $display("FAIL single_gnt c=%0d gnt=%b busy=%b done=%b want 0001/1/0000", c, gnt, busy, done);
      end
      // Dropping REQ exactly at the final tick must still complete normally.
      if (c == 39) req = 4'b0000;
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 4'b0001 || gnt !== 4'b0000 || led !== 2'b00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done done=%b gnt=%b led=%b busy=%b want 0001/0000/00/0", done, gnt, led, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 4'b0000 || gnt !== 4'b0000) begin
      n_err++;
      $display("FAIL single_done_pulse done=%b gnt=%b want 0000/0000", done, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_oh;
    int p;
    int g;
    do_reset();
    pattern = 8'b11_10_10_01;
    req = 4'b1111;
    for (int cyc = 0; cyc < 205; cyc++) begin
      @(negedge clk);
      g = cyc / 41;
      p = cyc % 41;
      exp_oh = 4'b0001 << (g % 4);
      if (p == 0 || p == 39) begin
        n_cmp++;
        if (gnt !== exp_oh) begin
          n_err++;
          $display("FAIL rr_gnt cyc=%0d got %b want %b", cyc, gnt, exp_oh);
        end
      end else if (p == 40) begin
        n_cmp++;
        if (gnt !== 4'b0000 || done !== exp_oh) begin
          n_err++;
          $display("FAIL rr_idle cyc=%0d gnt=%b done=%b want 0000/%b", cyc, gnt, done, exp_oh);
        end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_abort();
    do_reset();
    pattern = 8'b11_10_10_01;
    req = 4'b0100;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0100 || led !== 2'b10) begin
      n_err++;
      $display("FAIL abort_grant2 gnt=%b led=%b want 0100/10", gnt, led);
    end
    req = 4'b1100;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 12) begin
        n_cmp++;
        if (gnt !== 4'b0100) begin
          n_err++;
          $display("FAIL abort_no_preempt gnt=%b want 0100", gnt);
        end
      end
    end
    req = 4'b1000;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0000 || led !== 2'b00 || done !== 4'b0000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_edge gnt=%b led=%b done=%b busy=%b want 0000/00/0000/0", gnt, led, done, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b1000 || led !== 2'b11 || done !== 4'b0000) begin
      n_err++;
      $display("FAIL abort_next_grant gnt=%b led=%b done=%b want 1000/11/0000", gnt, led, done);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    pattern = 8'b11_10_10_01;
    req = 4'b1111;
    for (int c = 0; c <= 25; c++) begin
      @(negedge clk);
      if (c == 25) rst = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0000 || led !== 2'b00 || busy !== 1'b0 || done !== 4'b0000) begin
      n_err++;
      $display("FAIL midreset gnt=%b led=%b busy=%b done=%b want 0", gnt, led, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 4'b0001 || led !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_regrant gnt=%b led=%b want 0001/01", gnt, led);
    end
    req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pattern_latch();
    logic [1:0] exp_led;
    do_reset();
    pattern = 8'b00_00_00_01;
    req = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 5) pattern = 8'b00_00_00_10;
      exp_led = (((c / 10) % 2) == 0) ? 2'b01 : off_of(2'b01);
      if (c > 5) begin
        n_cmp++;
        if (led !== exp_led) begin
          n_err++;
          $display("FAIL latch_led c=%0d got %b want %b", c, led, exp_led);
        end
      end
      if (c == 39) req = 4'b0000;
    end
    @(negedge clk);
    n_cmp++;
    if (led !== 2'b00 || done !== 4'b0001) begin
      n_err++;
      $display("FAIL latch_idle led=%b done=%b want 00/0001", led, done);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req = 4'b0000;
    pattern = 8'h00;
    test_reset();
    test_single_grant();
    test_round_robin();
    test_abort();
    test_reset_mid_grant();
    test_pattern_latch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
